// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives the request; the slave returns status and digits.
interface bin2bcd_seq_if #(
    parameter int BIN_W = 16
);
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic [19:0]      bcd;
    logic             ovf4;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf4
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf4
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Results and status are registered and held until the next conversion.
module bin2bcd_seq #(
    parameter int BIN_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    bin2bcd_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0] sh_q, sh_d;
    logic [19:0]      work_q, work_d;
    logic [19:0]      bcd_q, bcd_d;
    logic             ovf4_q, ovf4_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [19:0]      adj;
    logic [19:0]      shifted;
    logic             unused_msb;

    always_comb begin
        adj = work_q;
        for (int i = 0; i < 5; i++) begin
            if (work_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // The top digit never reaches 5 before its last shift for BIN_W <= 16
    assign shifted    = {adj[18:0], sh_q[BIN_W-1]};
    assign unused_msb = adj[19];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        ovf4_d  = ovf4_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_d    = bus.bin;
                    work_d  = '0;
                    cnt_d   = 5'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted;
                sh_d   = {sh_q[BIN_W-2:0], 1'b0};
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    bcd_d   = shifted;
                    ovf4_d  = (shifted[19:16] != 4'd0);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            ovf4_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            ovf4_q  <= ovf4_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf4 = ovf4_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, held-start run,
// mid-conversion reset and a partial sweep against a division model.
module tb_bin2bcd_seq;

    localparam int W = 16;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bin2bcd_seq_if #(.BIN_W(W)) bus ();

    bin2bcd_seq #(.BIN_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    int   done_cyc[$];
    int   total = 0;
    int   passed = 0;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic ok_nibbles(input logic [19:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (b[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic monitor();
        logic        prev_done = 1'b0;
        logic        prev_rst = 1'b0;
        logic [19:0] prev_bcd = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_done) chk("done_width", bus.done, 0);
                if (!bus.done && prev_rst)
                    chk("bcd_hold", bus.bcd, prev_bcd);
                if (bus.done) begin
                    done_cyc.push_back(cyc);
                    chk("nibbles", ok_nibbles(bus.bcd), 1);
                    chk("busy_in_done", bus.busy, 1);
                    if (q.size() == 0) begin
                        chk("spurious_done", bus.done, 0);
                    end else begin
                        e = q.pop_front();
                        chk("bcd", bus.bcd, e.bcd);
                        chk("ovf4", bus.ovf4, e.ovf);
                        chk("latency", cyc - e.acc, W);
                    end
                end
            end
            prev_done = bus.done;
            prev_bcd  = bus.bcd;
            prev_rst  = rst_n;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", bus.busy, 0);
    endtask

    task automatic convert(input logic [15:0] v, input logic [19:0] eb,
                           input logic eo);
        exp_t e;
        wait_idle();
        bus.start = 1'b1;
        bus.bin   = v;
        e.bcd = eb;
        e.ovf = eo;
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 16'($urandom);
        chk("busy_after_accept", bus.busy, 1);
    endtask

    initial begin
        exp_t e;
        logic [15:0] v;
        tbl[0]  = '{16'd0,     20'h00000, 1'b0};
        tbl[1]  = '{16'd9999,  20'h09999, 1'b0};
        tbl[2]  = '{16'd10000, 20'h10000, 1'b1};
        tbl[3]  = '{16'd65535, 20'h65535, 1'b1};
        tbl[4]  = '{16'd1234,  20'h01234, 1'b0};
        tbl[5]  = '{16'd1,     20'h00001, 1'b0};
        tbl[6]  = '{16'd9,     20'h00009, 1'b0};
        tbl[7]  = '{16'd10,    20'h00010, 1'b0};
        tbl[8]  = '{16'd99,    20'h00099, 1'b0};
        tbl[9]  = '{16'd100,   20'h00100, 1'b0};
        tbl[10] = '{16'd32768, 20'h32768, 1'b1};
        tbl[11] = '{16'd59999, 20'h59999, 1'b1};

        bus.start = 1'b0;
        bus.bin   = '0;
        fork
            monitor();
        join_none

        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_bcd", bus.bcd, 0);
        chk("rst_ovf4", bus.ovf4, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            convert(tbl[i].bin, tbl[i].bcd, tbl[i].ovf);
        end
        wait_idle();

        // Held start: accepted values alternate between periods
        @(negedge clk);
        done_cyc.delete();
        for (int j = 0; j < 72; j++) begin
            bus.start = 1'b1;
            bus.bin   = (((j + j / 18) % 2) != 0) ? 16'd58 : 16'd42;
            if (j % 18 == 0) begin
                e.bcd = ref_bcd(int'(bus.bin));
                e.ovf = 1'b0;
                e.acc = cyc + 1;
                q.push_back(e);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("held_pulses", done_cyc.size(), 4);
        for (int i = 1; i < done_cyc.size(); i++) begin
            chk("done_spacing", done_cyc[i] - done_cyc[i-1], 18);
        end

        convert(16'd777, 20'h00777, 1'b0);
        wait_idle();
        bus.start = 1'b1;
        bus.bin   = 16'd500;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_bcd", bus.bcd, 0);
        chk("abort_ovf4", bus.ovf4, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        convert(16'd321, 20'h00321, 1'b0);

        for (int i = 0; i < 1100; i++) begin
            convert(16'(i), ref_bcd(i), i > 9999);
        end
        for (int i = 0; i < 1200; i++) begin
            v = 16'($urandom);
            convert(v, ref_bcd(int'(v)), v > 16'd9999);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL provide parameter BIN_W, default 16: binary input width; legal range 4..16.
REQ-002 SHALL provide port clk  input  1: single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1: conversion request; sampled on clk edges only while idle.
REQ-005 SHALL provide port bin  input  BIN_W: unsigned binary value; captured on the accepting edge.
REQ-006 SHALL provide port busy  output  1: high while a conversion is in progress (SHIFT or DONE state).
REQ-007 SHALL provide port done  output  1: one-cycle pulse marking new result valid.
REQ-008 SHALL provide port bcd  output  20: five packed BCD digits; [3:0] ones, [19:16] ten-thousands; each nibble 0..9.
REQ-009 SHALL provide port ovf4  output  1: result exceeds 9999, so it will not fit a four-digit display.

Function
REQ-010 SHALL implement states IDLE, SHIFT, DONE; all outputs registered.
REQ-011 IDLE: start=1 at an edge SHALL load bin into a shift register and clear the working BCD register. It SHALL also load the bit counter with BIN_W and enter SHIFT.
REQ-012 IDLE: start=0 SHALL hold state; bcd, ovf4 unchanged.
REQ-013 SHIFT: each edge SHALL first add 3 to every working digit >=5, then shift {working BCD, binary} left by one bit, then decrement the counter (double-dabble, one bit per cycle).
REQ-014 SHIFT SHALL last exactly BIN_W edges; the edge performing the final shift SHALL enter DONE.
REQ-015 That same edge SHALL write the final digits to bcd and set ovf4 = (result > 9999).
REQ-016 DONE: done=1 for exactly one cycle; next edge SHALL return to IDLE unconditionally.
REQ-017 Latency: start accepted at edge k -> bcd/ovf4 valid and done=1 from edge k+BIN_W to edge k+BIN_W+1 (k+16 for default).
REQ-018 busy SHALL be 1 from edge k through edge k+BIN_W+1; 0 in IDLE.
REQ-019 start SHALL be ignored in SHIFT and DONE (no queuing); start held high yields a conversion every BIN_W+2 cycles.
REQ-020 Changes on bin after the accepting edge SHALL NOT affect the result in progress.
REQ-021 bcd and ovf4 SHALL hold the previous result throughout a conversion; they update only on the DONE-entry edge.
REQ-022 Digit adjust SHALL use 4-bit arithmetic per digit; no digit SHALL ever exceed 9 after any shift.
REQ-023 For BIN_W < 16, unused upper digits SHALL read 0.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE and clear the counter, shift and working registers.
REQ-025 rst_n=0 SHALL immediately force busy=0, done=0, bcd=20'h00000, ovf4=0, independent of clk.
REQ-026 Reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow reset release.
REQ-027 First edge after rst_n rises SHALL be able to accept start.

Verification
REQ-028 bin=0, start pulse at edge k -> busy=1 from k; done=1 after edge k+16; bcd=0x00000, ovf4=0.
REQ-029 bin=9999 -> bcd=0x09999, ovf4=0; then bin=10000 -> bcd=0x10000, ovf4=1.
REQ-030 bin=65535 -> bcd=0x65535, ovf4=1; bin=1234 -> bcd=0x01234, ovf4=0.
REQ-031 start held high, bin=42 then 58 toggled each cycle -> done pulses exactly 18 cycles apart. Each result SHALL match the bin value sampled at its own accepting edge; bcd stable between pulses.
REQ-032 Convert 777 -> bcd=0x00777. Start 500 and assert rst_n=0 at edge k+8 -> bcd=0x00000, busy=0, no done pulse. Then 321 -> 0x00321 after 16+1 edges.
REQ-033 Exhaustive sweep 0..65535 against a reference model -> every bcd/ovf4 correct; no nibble >9; done width always 1 cycle.
